// File: rtl/line_mem_adapter_if.sv
// Bus bundle between the L1 data cache line port, the line/memory adapter and
// the narrow main-memory bus.
//
// Signal groups:
//   line_read_*   : cache line fill request and the assembled fill line
//   line_write_*  : cache line writeback request, data and completion
//   mem_read_*    : word read address/data channel toward main memory
//   mem_write_*   : word write address+data channel and write response
//
// Modports:
//   slave  : the adapter's view (takes line requests, drives memory requests)
//   master : the environment's view (cache plus memory driving the adapter)
interface line_mem_adapter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128,
    parameter int WORD_W = 32
);
    logic [ADDR_W-1:0] line_read_addr;
    logic              line_read_addr_valid;
    logic              line_read_addr_ready;
    logic [LINE_W-1:0] line_read_data;
    logic              line_read_data_valid;

    logic [ADDR_W-1:0] line_write_addr;
    logic              line_write_addr_valid;
    logic [LINE_W-1:0] line_write_data;
    logic              line_write_addr_ready;
    logic              line_write_resp_valid;

    logic [ADDR_W-1:0] mem_read_addr;
    logic              mem_read_addr_valid;
    logic              mem_read_addr_ready;
    logic [WORD_W-1:0] mem_read_data;
    logic              mem_read_data_valid;

    logic [ADDR_W-1:0] mem_write_addr;
    logic [WORD_W-1:0] mem_write_data;
    logic [3:0]        mem_strobe;
    logic              mem_write_addr_valid;
    logic              mem_write_addr_ready;
    logic              mem_write_resp_valid;

    modport slave (
        input  line_read_addr, line_read_addr_valid,
        output line_read_addr_ready, line_read_data, line_read_data_valid,
        input  line_write_addr, line_write_addr_valid, line_write_data,
        output line_write_addr_ready, line_write_resp_valid,
        output mem_read_addr, mem_read_addr_valid,
        input  mem_read_addr_ready, mem_read_data, mem_read_data_valid,
        output mem_write_addr, mem_write_data, mem_strobe, mem_write_addr_valid,
        input  mem_write_addr_ready, mem_write_resp_valid
    );

    modport master (
        output line_read_addr, line_read_addr_valid,
        input  line_read_addr_ready, line_read_data, line_read_data_valid,
        output line_write_addr, line_write_addr_valid, line_write_data,
        input  line_write_addr_ready, line_write_resp_valid,
        input  mem_read_addr, mem_read_addr_valid,
        output mem_read_addr_ready, mem_read_data, mem_read_data_valid,
        input  mem_write_addr, mem_write_data, mem_strobe, mem_write_addr_valid,
        output mem_write_addr_ready, mem_write_resp_valid
    );
endinterface

// File: rtl/line_mem_adapter.sv
// Line-to-word memory adapter.
// Splits each cache line fill or writeback into BEATS sequential word
// transactions on the narrow memory bus, one beat in flight at a time, and
// reports completion of the whole line with a one-cycle pulse.
//
// Ports:
//   clk_i : clock
//   rst_i : asynchronous active-high reset, aborts any transaction in flight
//   bus   : line_mem_adapter_if.slave, cache line side plus memory word side
//
// All outputs come straight from flops; their next values are derived from
// the next FSM state so that requests appear the cycle the state is entered.
module line_mem_adapter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128,
    parameter int WORD_W = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    line_mem_adapter_if.slave bus
);
    localparam int BEATS    = LINE_W / WORD_W;
    localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WORD_OFF = $clog2(WORD_W / 8);
    localparam int LINE_OFF = $clog2(LINE_W / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LINE_W-1:0] wbuf_q, wbuf_d;
    logic [LINE_W-1:0] rbuf_q, rbuf_d;
    logic              is_read_q, is_read_d;

    logic              rd_valid_q, rd_valid_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [3:0]        strobe_q, strobe_d;
    logic              rd_done_q, rd_done_d;
    logic              wr_done_q, wr_done_d;

    logic              unused_offset_bits;

    // The low line-offset address bits are discarded when a base is latched;
    // gathering them here keeps that explicit.
    assign unused_offset_bits = ^{bus.line_read_addr[LINE_OFF-1:0],
                                  bus.line_write_addr[LINE_OFF-1:0]};

    // Next-state logic. IDLE favours reads over writes; a write that loses
    // the race simply stays pending on its held valid and is picked up on a
    // later IDLE cycle. DONE always returns to IDLE without looking at the
    // requests, which is what forces one idle cycle between line transactions.
    // Read words land in their own line register so a writeback never disturbs
    // the last fill line presented to the cache.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        base_d    = base_q;
        wbuf_d    = wbuf_q;
        rbuf_d    = rbuf_q;
        is_read_d = is_read_q;

        case (state_q)
            IDLE: begin
                if (bus.line_read_addr_valid) begin
                    base_d    = {bus.line_read_addr[ADDR_W-1:LINE_OFF], {LINE_OFF{1'b0}}};
                    beat_d    = '0;
                    is_read_d = 1'b1;
                    state_d   = RD_REQ;
                end else if (bus.line_write_addr_valid) begin
                    base_d    = {bus.line_write_addr[ADDR_W-1:LINE_OFF], {LINE_OFF{1'b0}}};
                    wbuf_d    = bus.line_write_data;
                    beat_d    = '0;
                    is_read_d = 1'b0;
                    state_d   = WR_REQ;
                end
            end
            RD_REQ: begin
                if (bus.mem_read_addr_ready) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus.mem_read_data_valid) begin
                    rbuf_d[beat_q*WORD_W +: WORD_W] = bus.mem_read_data;
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (bus.mem_write_addr_ready) begin
                    state_d = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (bus.mem_write_resp_valid) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = WR_REQ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, taken from the next state so the
    // registered outputs line up with the state they belong to. The word
    // address and write data only depend on base and beat, so they stay
    // stable for as long as memory stalls a request.
    always_comb begin
        rd_valid_d = (state_d == RD_REQ);
        wr_valid_d = (state_d == WR_REQ);
        addr_d     = base_d + {{(ADDR_W-BEAT_W-WORD_OFF){1'b0}}, beat_d, {WORD_OFF{1'b0}}};
        wdata_d    = wbuf_d[beat_d*WORD_W +: WORD_W];
        strobe_d   = wr_valid_d ? 4'hF : 4'h0;
        rd_done_d  = (state_d == DONE) && is_read_d;
        wr_done_d  = (state_d == DONE) && !is_read_d;
    end

    // State and output registers. Reset clears everything at once, so any
    // request already on the memory bus is withdrawn immediately and no
    // completion pulse can follow an aborted line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            base_q     <= '0;
            wbuf_q     <= '0;
            rbuf_q     <= '0;
            is_read_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            strobe_q   <= 4'h0;
            rd_done_q  <= 1'b0;
            wr_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            base_q     <= base_d;
            wbuf_q     <= wbuf_d;
            rbuf_q     <= rbuf_d;
            is_read_q  <= is_read_d;
            rd_valid_q <= rd_valid_d;
            wr_valid_q <= wr_valid_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            strobe_q   <= strobe_d;
            rd_done_q  <= rd_done_d;
            wr_done_q  <= wr_done_d;
        end
    end

    assign bus.line_read_addr_ready  = rd_done_q;
    assign bus.line_read_data_valid  = rd_done_q;
    assign bus.line_read_data        = rbuf_q;
    assign bus.line_write_addr_ready = wr_done_q;
    assign bus.line_write_resp_valid = wr_done_q;
    assign bus.mem_read_addr         = addr_q;
    assign bus.mem_read_addr_valid   = rd_valid_q;
    assign bus.mem_write_addr        = addr_q;
    assign bus.mem_write_data        = wdata_q;
    assign bus.mem_strobe            = strobe_q;
    assign bus.mem_write_addr_valid  = wr_valid_q;
endmodule

// File: tb/tb_line_mem_adapter.sv
// Testbench for line_mem_adapter.
// A word-addressed memory responder with configurable stalls, latency and
// spurious read-data pulses drives the memory side. A line-level model
// (expected word addresses per line, expected write words, expected fill
// lines built from memory contents) is checked against the DUT every cycle,
// and each directed scenario adds hand-computed literal expectations.
module tb_line_mem_adapter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    // Free-running cycle index used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    line_mem_adapter_if bus ();

    line_mem_adapter dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [31:0]  mem [logic [31:0]];
    int           rd_stall = 0;
    int           wr_stall = 0;
    bit           rd_rand = 1'b0;
    bit           spur_en = 1'b0;
    bit           real_deliv = 1'b0;
    int           rd_acc_cnt = 0;

    logic [31:0]  exp_rd_addr [$];
    logic [63:0]  exp_wr [$];
    logic [127:0] exp_line [$];
    int           exp_wr_done = 0;
    int           rd_pulse_cnt = 0;
    int           wr_pulse_cnt = 0;
    int unsigned  rd_pulse_cyc = 0;
    int unsigned  wr_pulse_cyc = 0;

    // One comparison: counts it and reports a failing one.
    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Memory contents: preloaded words where given, otherwise a fixed hash.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h0135_7531;
    endfunction

    // Line-side requester: queues the expected memory traffic for the line,
    // holds the request until its completion pulse and returns the latency
    // in cycles from the cycle the request was first presented.
    task automatic applyStimulus(input bit is_wr, input logic [31:0] addr,
                                 input logic [127:0] wdata, output int lat);
        logic [31:0]  base;
        logic [127:0] line;
        int unsigned  start;
        base = {addr[31:4], 4'b0};
        if (!is_wr) begin
            for (int k = 0; k < 4; k++) begin
                exp_rd_addr.push_back(base + 32'(4 * k));
                line[32*k +: 32] = mem_word(base + 32'(4 * k));
            end
            exp_line.push_back(line);
            bus.line_read_addr       = addr;
            bus.line_read_addr_valid = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                exp_wr.push_back({base + 32'(4 * k), wdata[32*k +: 32]});
            end
            exp_wr_done++;
            bus.line_write_addr       = addr;
            bus.line_write_data       = wdata;
            bus.line_write_addr_valid = 1'b1;
        end
        start = cyc;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (rst) break;
            if ((!is_wr && bus.line_read_addr_ready) || (is_wr && bus.line_write_addr_ready)) begin
                lat = int'(cyc - start);
                break;
            end
        end
        if (!is_wr) bus.line_read_addr_valid = 1'b0;
        else        bus.line_write_addr_valid = 1'b0;
        if (lat < 0 && !rst) checkOutput(is_wr ? "wr_timeout" : "rd_timeout", 128'd1, 128'd0);
    endtask

    // Memory responder: one accepted read or write at a time, read data
    // after a fixed or random latency, write response the cycle after
    // acceptance, optional junk read-data pulses while a read is requested.
    initial begin : memory
        bit          rd_pend = 1'b0;
        int          rd_cnt = 0;
        logic [31:0] rd_addr = '0;
        bit          wr_pend = 1'b0;
        int          rs = 0;
        int          ws = 0;
        bus.mem_read_addr_ready  = 1'b0;
        bus.mem_read_data        = '0;
        bus.mem_read_data_valid  = 1'b0;
        bus.mem_write_addr_ready = 1'b0;
        bus.mem_write_resp_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_read_addr_ready  = 1'b0;
            bus.mem_read_data_valid  = 1'b0;
            bus.mem_read_data        = '0;
            bus.mem_write_addr_ready = 1'b0;
            bus.mem_write_resp_valid = 1'b0;
            real_deliv = 1'b0;
            if (rst) begin
                rd_pend = 1'b0;
                wr_pend = 1'b0;
                rs = 0;
                ws = 0;
                continue;
            end
            if (bus.mem_read_addr_valid) checkOutput("rd_single_outstanding", 128'(rd_pend), 128'd0);
            if (rd_pend) begin
                if (rd_cnt == 0) begin
                    bus.mem_read_data_valid = 1'b1;
                    bus.mem_read_data       = mem_word(rd_addr);
                    real_deliv = 1'b1;
                    rd_pend = 1'b0;
                end else begin
                    rd_cnt--;
                end
            end else if (bus.mem_read_addr_valid) begin
                if (rs < rd_stall) begin
                    rs++;
                end else begin
                    bus.mem_read_addr_ready = 1'b1;
                    rd_pend = 1'b1;
                    rd_addr = bus.mem_read_addr;
                    rd_cnt  = rd_rand ? int'($urandom_range(0, 7)) : 0;
                    rs = 0;
                    rd_acc_cnt++;
                end
                if (spur_en && $urandom_range(0, 1) == 1) begin
                    bus.mem_read_data_valid = 1'b1;
                    bus.mem_read_data       = 32'hDEAD_BEEF;
                end
            end
            if (wr_pend) begin
                bus.mem_write_resp_valid = 1'b1;
                wr_pend = 1'b0;
            end else if (bus.mem_write_addr_valid) begin
                if (ws < wr_stall) begin
                    ws++;
                end else begin
                    bus.mem_write_addr_ready = 1'b1;
                    mem[bus.mem_write_addr] = bus.mem_write_data;
                    wr_pend = 1'b1;
                    ws = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the line-level model, sampled mid-cycle.
    // The fill line output is expected to show word k of a line as soon as
    // the k-th genuine read word has been delivered, and to hold otherwise.
    initial begin : compare
        logic [127:0] model_line = '0;
        int           model_beat = 0;
        bit           stage_v = 1'b0;
        logic [31:0]  stage_w = '0;
        int           stage_b = 0;
        bit           prev_rv = 1'b0;
        bit           prev_rhs = 1'b0;
        logic [31:0]  prev_raddr = '0;
        bit           prev_wv = 1'b0;
        bit           prev_whs = 1'b0;
        logic [63:0]  prev_wbeat = '0;
        bit           prev_rdone = 1'b0;
        bit           prev_wdone = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_line = '0;
                model_beat = 0;
                stage_v = 1'b0;
                prev_rv = 1'b0;
                prev_rhs = 1'b0;
                prev_wv = 1'b0;
                prev_whs = 1'b0;
                prev_rdone = 1'b0;
                prev_wdone = 1'b0;
                exp_rd_addr.delete();
                exp_wr.delete();
                exp_line.delete();
                exp_wr_done = 0;
                continue;
            end
            if (stage_v) begin
                model_line[32*stage_b +: 32] = stage_w;
                stage_v = 1'b0;
            end
            checkOutput("line_read_data", bus.line_read_data, model_line);
            if (bus.mem_read_data_valid && real_deliv) begin
                stage_v = 1'b1;
                stage_w = bus.mem_read_data;
                stage_b = model_beat;
                model_beat = (model_beat + 1) % 4;
            end

            checkOutput("one_mem_valid", 128'(bus.mem_read_addr_valid && bus.mem_write_addr_valid), 128'd0);

            if (bus.mem_read_addr_valid) begin
                if (prev_rv && !prev_rhs) begin
                    checkOutput("rd_addr_stable", bus.mem_read_addr, prev_raddr);
                end else if (exp_rd_addr.size() == 0) begin
                    checkOutput("rd_unexpected_req", 128'd1, 128'd0);
                end else begin
                    checkOutput("mem_read_addr", bus.mem_read_addr, exp_rd_addr.pop_front());
                end
            end
            prev_rhs   = bus.mem_read_addr_valid && bus.mem_read_addr_ready;
            prev_rv    = bus.mem_read_addr_valid;
            prev_raddr = bus.mem_read_addr;

            if (bus.mem_write_addr_valid) begin
                checkOutput("mem_strobe", bus.mem_strobe, 128'hF);
                if (prev_wv && !prev_whs) begin
                    checkOutput("wr_beat_stable", {bus.mem_write_addr, bus.mem_write_data}, prev_wbeat);
                end else if (exp_wr.size() == 0) begin
                    checkOutput("wr_unexpected_req", 128'd1, 128'd0);
                end else begin
                    checkOutput("mem_write_beat", {bus.mem_write_addr, bus.mem_write_data}, exp_wr.pop_front());
                end
            end
            prev_whs   = bus.mem_write_addr_valid && bus.mem_write_addr_ready;
            prev_wv    = bus.mem_write_addr_valid;
            prev_wbeat = {bus.mem_write_addr, bus.mem_write_data};

            checkOutput("rd_pulse_pair", 128'(bus.line_read_data_valid), 128'(bus.line_read_addr_ready));
            checkOutput("wr_pulse_pair", 128'(bus.line_write_resp_valid), 128'(bus.line_write_addr_ready));
            if (bus.line_read_addr_ready) begin
                checkOutput("rd_pulse_width", 128'(prev_rdone), 128'd0);
                if (exp_line.size() == 0) checkOutput("rd_unexpected_pulse", 128'd1, 128'd0);
                else checkOutput("rd_line_at_pulse", bus.line_read_data, exp_line.pop_front());
                rd_pulse_cnt++;
                rd_pulse_cyc = cyc;
            end
            if (bus.line_write_addr_ready) begin
                checkOutput("wr_pulse_width", 128'(prev_wdone), 128'd0);
                if (exp_wr_done == 0) checkOutput("wr_unexpected_pulse", 128'd1, 128'd0);
                else exp_wr_done--;
                wr_pulse_cnt++;
                wr_pulse_cyc = cyc;
            end
            prev_rdone = bus.line_read_addr_ready;
            prev_wdone = bus.line_write_addr_ready;
        end
    end

    // Run-time bound so the bench always reaches its summary.
    initial begin : watchdog
        #500000;
        checkOutput("watchdog", 128'd1, 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Directed scenarios.
    initial begin : main
        int           l1, l2, l5, c_rd, c_wr, c0, rise;
        int unsigned  p;
        logic [127:0] saved;
        bus.line_read_addr        = '0;
        bus.line_read_addr_valid  = 1'b0;
        bus.line_write_addr       = '0;
        bus.line_write_addr_valid = 1'b0;
        bus.line_write_data       = '0;

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rd_valid", 128'(bus.mem_read_addr_valid), 128'd0);
        checkOutput("reset_wr_valid", 128'(bus.mem_write_addr_valid), 128'd0);
        checkOutput("reset_rd_addr", bus.mem_read_addr, 128'd0);
        checkOutput("reset_strobe", bus.mem_strobe, 128'd0);
        checkOutput("reset_line_data", bus.line_read_data, 128'd0);
        checkOutput("reset_rd_ready", 128'(bus.line_read_addr_ready), 128'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] fill at zero wait");
        mem[32'h1230] = 32'hA0;
        mem[32'h1234] = 32'hA1;
        mem[32'h1238] = 32'hA2;
        mem[32'h123C] = 32'hA3;
        applyStimulus(1'b0, 32'h0000_1234, '0, l1);
        checkOutput("t1_latency", 128'(l1), 128'd9);
        checkOutput("t1_line", bus.line_read_data, 128'h000000A3_000000A2_000000A1_000000A0);
        @(posedge clk);
        #1;
        checkOutput("t1_pulse_single", 128'(bus.line_read_addr_ready), 128'd0);

        $display("[TB] writeback with stalled memory");
        wr_stall = 3;
        c_wr = wr_pulse_cnt;
        applyStimulus(1'b1, 32'h0000_2000, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, l2);
        @(negedge clk);
        checkOutput("t2_word0", mem_word(32'h2000), 128'hAAAAAAAA);
        checkOutput("t2_word3", mem_word(32'h200C), 128'hDDDDDDDD);
        checkOutput("t2_pulses", 128'(wr_pulse_cnt - c_wr), 128'd1);
        wr_stall = 0;
        @(posedge clk);
        #1;

        $display("[TB] simultaneous read and write");
        c_rd = rd_pulse_cnt;
        c_wr = wr_pulse_cnt;
        fork
            applyStimulus(1'b0, 32'h0000_3000, '0, l1);
            applyStimulus(1'b1, 32'h0000_3100, 128'h44444444_33333333_22222222_11111111, l2);
        join
        @(negedge clk);
        checkOutput("t3_read_latency", 128'(l1), 128'd9);
        checkOutput("t3_write_latency", 128'(l2), 128'd19);
        checkOutput("t3_order", 128'(rd_pulse_cyc < wr_pulse_cyc), 128'd1);
        checkOutput("t3_rd_pulses", 128'(rd_pulse_cnt - c_rd), 128'd1);
        checkOutput("t3_wr_pulses", 128'(wr_pulse_cnt - c_wr), 128'd1);
        @(posedge clk);
        #1;

        $display("[TB] random read latency with junk data pulses");
        rd_rand = 1'b1;
        spur_en = 1'b1;
        c_rd = rd_pulse_cnt;
        applyStimulus(1'b0, 32'h0000_4000, '0, l1);
        applyStimulus(1'b0, 32'h0000_500C, '0, l2);
        @(negedge clk);
        checkOutput("t4_rd_pulses", 128'(rd_pulse_cnt - c_rd), 128'd2);
        rd_rand = 1'b0;
        spur_en = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] reset during a fill");
        c_rd = rd_pulse_cnt;
        c0 = rd_acc_cnt;
        fork
            applyStimulus(1'b0, 32'h0000_6000, '0, l5);
            begin
                for (int i = 0; i < 100 && rd_acc_cnt < c0 + 2; i++) @(negedge clk);
                @(posedge clk);
                @(posedge clk);
                #3;
                checkOutput("t5_pre_valid", 128'(bus.mem_read_addr_valid), 128'd1);
                checkOutput("t5_pre_addr", bus.mem_read_addr, 128'h6008);
                rst = 1'b1;
                #1;
                checkOutput("t5_rd_valid", 128'(bus.mem_read_addr_valid), 128'd0);
                checkOutput("t5_rd_addr", bus.mem_read_addr, 128'd0);
                checkOutput("t5_line_data", bus.line_read_data, 128'd0);
                checkOutput("t5_rd_ready", 128'(bus.line_read_addr_ready), 128'd0);
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
            end
        join
        @(posedge clk);
        #1;
        mem[32'h40] = 32'h11;
        mem[32'h44] = 32'h22;
        mem[32'h48] = 32'h33;
        mem[32'h4C] = 32'h44;
        applyStimulus(1'b0, 32'h0000_0040, '0, l5);
        checkOutput("t5_refill_latency", 128'(l5), 128'd9);
        checkOutput("t5_refill_line", bus.line_read_data, 128'h00000044_00000033_00000022_00000011);
        @(negedge clk);
        checkOutput("t5_rd_pulses", 128'(rd_pulse_cnt - c_rd), 128'd1);
        @(posedge clk);
        #1;

        $display("[TB] back-to-back fills");
        applyStimulus(1'b0, 32'h0000_7000, '0, l1);
        p = cyc;
        saved = bus.line_read_data;
        rise = -1;
        fork
            applyStimulus(1'b0, 32'h0000_7010, '0, l2);
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    if (bus.mem_read_addr_valid) begin
                        rise = int'(cyc - p);
                        break;
                    end
                end
                checkOutput("t6_gap", 128'(rise), 128'd2);
                checkOutput("t6_line_hold", bus.line_read_data, saved);
            end
        join
        checkOutput("t6_second_latency", 128'(l2), 128'd10);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/line_mem_adapter.md
Name: line_mem_adapter

Overview:
Sits directly downstream of the L1 data cache's 128-bit memory port. Converts each 128-bit line fill (read) or line writeback (write) into four sequential 32-bit word transactions on the narrower main-memory bus. Completion is signalled back to the cache with one-cycle pulses. At most one line transaction and one memory beat are outstanding at any time.

Parameters:
- ADDR_W, 32, address width on both sides.
- LINE_W, 128, line width on the cache side.
- WORD_W, 32, word width on the memory side. BEATS = LINE_W/WORD_W = 4; BEATS must be a power of two.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- line_read_addr  in  ADDR_W  line fill address; bits [3:0] are ignored.
- line_read_addr_valid  in  1  fill request; held until line_read_addr_ready.
- line_read_addr_ready  out  1  one-cycle pulse on fill completion.
- line_read_data  out  LINE_W  assembled fill line.
- line_read_data_valid  out  1  one-cycle pulse, coincident with line_read_addr_ready.
- line_write_addr  in  ADDR_W  writeback address; bits [3:0] are ignored.
- line_write_addr_valid  in  1  writeback request; held until line_write_addr_ready.
- line_write_data  in  LINE_W  writeback line.
- line_write_addr_ready  out  1  one-cycle pulse on writeback completion.
- line_write_resp_valid  out  1  one-cycle pulse, coincident with line_write_addr_ready.
- mem_read_addr  out  ADDR_W  word address.
- mem_read_addr_valid  out  1  word read request.
- mem_read_addr_ready  in  1  memory accepts the read address.
- mem_read_data  in  WORD_W  read word.
- mem_read_data_valid  in  1  read word valid.
- mem_write_addr  out  ADDR_W  word address.
- mem_write_data  out  WORD_W  write word.
- mem_strobe  out  4  byte enables; always 4'hF while mem_write_addr_valid is high.
- mem_write_addr_valid  out  1  word write request; address and data are presented together.
- mem_write_addr_ready  in  1  memory accepts the address and data.
- mem_write_resp_valid  in  1  word write complete.

Behaviour:
- Reset (asynchronous): state=IDLE, beat=0, line buffer=0, all outputs 0. Reset mid-transaction aborts it: no completion pulse is emitted and memory-side valids drop immediately.
- All outputs are registered.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
- IDLE:
  - Samples both line-side valids.
  - Read has priority: if line_read_addr_valid, latch base={addr[31:4],4'b0}, beat=0, go to RD_REQ.
  - Else if line_write_addr_valid, latch base and line_write_data into the line buffer, go to WR_REQ.
  - A write that arrives simultaneously with a read is serviced after the read completes, provided it is still held.
- RD_REQ:
  - mem_read_addr_valid=1, mem_read_addr=base+4*beat.
  - Address and valid stay stable until mem_read_addr_ready; then go to RD_WAIT.
- RD_WAIT:
  - On mem_read_data_valid, write buffer[32*beat+:32]=mem_read_data.
  - If beat==3, go to DONE; else beat++ and return to RD_REQ.
  - mem_read_data_valid is ignored in every other state.
- WR_REQ:
  - mem_write_addr_valid=1, mem_write_addr=base+4*beat, mem_write_data=buffer[32*beat+:32], mem_strobe=4'hF.
  - On mem_write_addr_ready, go to WR_WAIT.
- WR_WAIT:
  - On mem_write_resp_valid: if beat==3, go to DONE; else beat++ and return to WR_REQ.
  - mem_write_resp_valid is ignored in every other state.
- DONE (one cycle):
  - After a read: line_read_addr_ready=line_read_data_valid=1. line_read_data holds the buffer from DONE until the next read's first beat is captured.
  - After a write: line_write_addr_ready=line_write_resp_valid=1.
  - Return to IDLE. IDLE never accepts a request in the same cycle as DONE, so back-to-back requests incur one idle cycle.
- Latency: with memory ready in the same cycle and data/response returning the next cycle, each beat takes 2 cycles. The completion pulse appears 9 cycles after the cycle in which IDLE sampled the valid.
- Address arithmetic is modulo 2^ADDR_W. Word addresses never cross the line, since base[3:0]=0.
- A requester dropping its valid mid-transaction is unsupported; the adapter still completes all beats and pulses.

Test Plan:
1. Fill from 0x0000_1234, memory returns words 0xA0,0xA1,0xA2,0xA3 at zero wait → mem_read_addr=0x1230,0x1234,0x1238,0x123C in order; line_read_data=0x000000A3_000000A2_000000A1_000000A0; single-cycle ready/valid pulse 9 cycles after the request.
2. Writeback to 0x0000_2000 with data 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA; memory holds mem_write_addr_ready low for 3 cycles on each beat → words AAAAAAAA..DDDDDDDD written to 0x2000..0x200C, strobe=4'hF, addr/data stable while stalled; one line_write_resp_valid pulse.
3. Read and write valid asserted in the same cycle → the entire read (4 beats) completes first, then the write; exactly one pulse of each, in that order.
4. Random read-data latency of 0–7 cycles with spurious mem_read_data_valid pulses in RD_REQ → spurious pulses ignored; buffer correct; never more than one outstanding beat.
5. rst_i asserted during beat 2 of a fill → all outputs 0 asynchronously; no completion pulse; a subsequent fill to 0x40 completes normally from beat 0.
6. Two fills back-to-back, requester re-asserting valid immediately → second mem_read_addr_valid rises exactly 2 cycles after the first completion pulse; line_read_data stays stable until the second fill's first capture.
